// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter one frame at a time over the
// tx_dv / tx_ready / tx_done handshake.
module uart_tx_buffer #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          busy,
    output logic          tx_dv,
    output logic [7:0]    tx_byte,
    input  logic          tx_ready,
    input  logic          tx_done
);
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          pop, push, drop;

    // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
    assign pop  = (state == IDLE) && !empty && tx_ready;
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_byte <= mem[rd_ptr];
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // GAP waits out the transmitter's cleanup cycle; a strobe there would be lost.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!empty && tx_ready) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tx_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_done) state_nxt = GAP;
            GAP:       if (!tx_done && tx_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_dv = (state == LAUNCH);
        busy  = (state != IDLE);
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a negedge-driven transmitter model.
module tb_uart_tx_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       full, empty, overflow, busy, tx_dv;
    logic [4:0] count;
    logic [7:0] tx_byte;
    logic       tx_ready = 1'b0;
    logic       tx_done = 1'b0;

    logic       hold = 1'b0;
    logic [7:0] rx_q [$];
    int         m_cnt = 0;
    int         dv_cnt = 0;
    int         lost = 0;
    int         dbl_dv = 0;
    logic       dv_prev = 1'b0;
    int         total = 0;
    int         bad = 0;

    uart_tx_buffer #(.DEPTH(16), .CW(5)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .busy(busy), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .tx_ready(tx_ready), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Transmitter: busy for a frame, tx_done high 2 cycles, tx_ready back one cycle early.
    always @(negedge clk) begin
        if (tx_dv) begin
            dv_cnt++;
            if (dv_prev) dbl_dv++;
            if (!tx_ready || m_cnt != 0) lost++;
            else begin
                rx_q.push_back(tx_byte);
                m_cnt = 6;
            end
        end
        dv_prev = tx_dv;
        if (m_cnt > 0) begin
            tx_done  = (m_cnt <= 2);
            tx_ready = (m_cnt == 1);
            m_cnt--;
        end else begin
            tx_done  = 1'b0;
            tx_ready = !hold;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max, output bit ok);
        int n = 0;
        while (!(empty && !busy) && n < max) begin
            step();
            n++;
        end
        ok = empty && !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++; if (count !== 5'd0)  begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1)  begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0)   begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (tx_dv !== 1'b0)  begin bad++; $display("FAIL reset_txdv got=%b want=0", tx_dv); end
        total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_txbyte got=%h want=00", tx_byte); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit ok;
        rx_q.delete();
        wr_en = 1'b1; wr_data = 8'h41;
        step();
        wr_en = 1'b0;
        total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count_e0 got=%0d want=1", count); end
        total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL single_txdv_e0 got=%b want=0", tx_dv); end
        step();
        total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL single_txdv_e1 got=%b want=1", tx_dv); end
        total++; if (tx_byte !== 8'h41) begin bad++; $display("FAIL single_txbyte got=%h want=41", tx_byte); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL single_count_e1 got=%0d want=0", count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        step();
        total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL single_txdv_e2 got=%b want=0", tx_dv); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_e2 got=%b want=1", busy); end
        wait_drain(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout busy=%b empty=%b want idle", busy, empty); end
        total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL single_rxsize got=%0d want=1", rx_q.size()); end
        else begin
            total++; if (rx_q[0] !== 8'h41) begin bad++; $display("FAIL single_rxbyte got=%h want=41", rx_q[0]); end
        end
    endtask

    task automatic test_burst_overflow();
        hold = 1'b1;
        step();
        step();
        rx_q.delete();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL burst_full got=%b want=1", full); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL burst_count got=%0d want=16", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL burst_ovf_pre got=%b want=0", overflow); end
        wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drop_ovf got=%b want=1", overflow); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL drop_count got=%0d want=16", count); end
        total++; if (dv_cnt !== 1) begin bad++; $display("FAIL burst_no_launch got=%0d want=1", dv_cnt); end
    endtask

    task automatic test_clr_ovf();
        clr_ovf = 1'b1;
        step();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b want=0", overflow); end
        wr_en = 1'b1; wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_vs_drop got=%b want=1", overflow); end
        step();
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_again got=%b want=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        hold = 1'b0;
        wr_en = 1'b1; wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        total++; if (tx_dv !== 1'b1) begin bad++; $display("FAIL pp_txdv got=%b want=1", tx_dv); end
        total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL pp_txbyte got=%h want=00", tx_byte); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL pp_count got=%0d want=16", count); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL pp_full got=%b want=1", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%b want=0", overflow); end
        wait_drain(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL drain_timeout count=%0d busy=%b want idle", count, busy); end
        total++; if (rx_q.size() !== 17) begin bad++; $display("FAIL drain_size got=%0d want=17", rx_q.size()); end
        else begin
            for (int i = 0; i < 17; i++) begin
                logic [7:0] exp_b;
                exp_b = (i == 16) ? 8'h55 : 8'(i);
                total++;
                if (rx_q[i] !== exp_b) begin bad++; $display("FAIL drain_byte%0d got=%h want=%h", i, rx_q[i], exp_b); end
            end
        end
        total++; if (dv_cnt !== 18) begin bad++; $display("FAIL dv_per_byte got=%0d want=18", dv_cnt); end
        total++; if (lost !== 0) begin bad++; $display("FAIL gap_lost_strobe got=%0d want=0", lost); end
        total++; if (dbl_dv !== 0) begin bad++; $display("FAIL dv_width got=%0d want=0", dbl_dv); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int dv_before;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hA1 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        total++; if (count !== 5'd3) begin bad++; $display("FAIL mid_count got=%0d want=3", count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        total++; if (tx_byte !== 8'hA1) begin bad++; $display("FAIL mid_txbyte got=%h want=a1", tx_byte); end
        rst_n = 1'b0;
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL arst_empty got=%b want=1", empty); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", busy); end
        total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL arst_txbyte got=%h want=00", tx_byte); end
        total++; if (tx_dv !== 1'b0) begin bad++; $display("FAIL arst_txdv got=%b want=0", tx_dv); end
        step();
        step();
        rst_n = 1'b1;
        dv_before = dv_cnt;
        for (int i = 0; i < 30; i++) step();
        total++; if (dv_cnt !== dv_before) begin bad++; $display("FAIL post_rst_dv got=%0d want=%0d", dv_cnt, dv_before); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL post_rst_count got=%0d want=0", count); end
        rx_q.delete();
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        wait_drain(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL post_rst_timeout busy=%b want idle", busy); end
        total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL post_rst_rxsize got=%0d want=1", rx_q.size()); end
        else begin
            total++; if (rx_q[0] !== 8'h77) begin bad++; $display("FAIL post_rst_rxbyte got=%h want=77", rx_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_overflow();
        test_clr_ovf();
        test_full_push_pop();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
